// File: rtl/ps2_pkg.sv
// Shared scan-code constants, prefix state type and the Set-2 to ASCII lookup
// used by the PS/2 key decoder.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_LSHIFT   = 8'h12;
    localparam logic [7:0] SC_RSHIFT   = 8'h59;
    localparam logic [7:0] SC_CAPS     = 8'h58;
    localparam logic [7:0] SC_KP_ENTER = 8'h5A;

    localparam logic [7:0] ASCII_CR    = 8'h0D;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BREAK   = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_e;

    typedef struct packed {
        logic       hit;
        logic [7:0] chr;
    } sc_lookup_t;

    // Letters come out uppercase from the table and are folded to lowercase
    // afterwards, so one entry per letter serves both cases.
    function automatic sc_lookup_t sc2ascii(input logic [7:0] code, input logic upper);
        sc_lookup_t r;
        r.hit = 1'b1;
        r.chr = 8'h00;
        case (code)
            8'h1C: r.chr = 8'h41; 8'h32: r.chr = 8'h42; 8'h21: r.chr = 8'h43;
            8'h23: r.chr = 8'h44; 8'h24: r.chr = 8'h45; 8'h2B: r.chr = 8'h46;
            8'h34: r.chr = 8'h47; 8'h33: r.chr = 8'h48; 8'h43: r.chr = 8'h49;
            8'h3B: r.chr = 8'h4A; 8'h42: r.chr = 8'h4B; 8'h4B: r.chr = 8'h4C;
            8'h3A: r.chr = 8'h4D; 8'h31: r.chr = 8'h4E; 8'h44: r.chr = 8'h4F;
            8'h4D: r.chr = 8'h50; 8'h15: r.chr = 8'h51; 8'h2D: r.chr = 8'h52;
            8'h1B: r.chr = 8'h53; 8'h2C: r.chr = 8'h54; 8'h3C: r.chr = 8'h55;
            8'h2A: r.chr = 8'h56; 8'h1D: r.chr = 8'h57; 8'h22: r.chr = 8'h58;
            8'h35: r.chr = 8'h59; 8'h1A: r.chr = 8'h5A;
            8'h45: r.chr = 8'h30; 8'h16: r.chr = 8'h31; 8'h1E: r.chr = 8'h32;
            8'h26: r.chr = 8'h33; 8'h25: r.chr = 8'h34; 8'h2E: r.chr = 8'h35;
            8'h36: r.chr = 8'h36; 8'h3D: r.chr = 8'h37; 8'h3E: r.chr = 8'h38;
            8'h46: r.chr = 8'h39;
            8'h0E: r.chr = 8'h60; 8'h4E: r.chr = 8'h2D; 8'h55: r.chr = 8'h3D;
            8'h54: r.chr = 8'h5B; 8'h5B: r.chr = 8'h5D; 8'h5D: r.chr = 8'h5C;
            8'h4C: r.chr = 8'h3B; 8'h52: r.chr = 8'h27; 8'h41: r.chr = 8'h2C;
            8'h49: r.chr = 8'h2E; 8'h4A: r.chr = 8'h2F;
            8'h29: r.chr = 8'h20;
            8'h5A: r.chr = ASCII_CR;
            8'h66: r.chr = 8'h08;
            default: r.hit = 1'b0;
        endcase
        if (!upper && (r.chr >= 8'h41) && (r.chr <= 8'h5A)) begin
            r.chr = r.chr | 8'h20;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through buffer: the head entry is visible on rd_data while
// rd_valid is high. A push into a full buffer is accepted only when a pop
// frees the head slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     wr_ready,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    assign rd_valid = (count_q != '0);
    assign pop      = rd_en & rd_valid;
    assign wr_ready = (count_q != FULL_CNT) | pop;
    assign push     = wr_en & wr_ready;
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Next pointers, occupancy and storage contents
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Register storage and pointers; reset empties the buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ps2_key_ascii_decoder.sv
// PS/2 Set-2 scan-code stream to buffered ASCII characters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no prefix pending; next byte is a make code or a prefix
// BREAK   | F0 seen; next byte is the released key
// EXT     | E0 seen; next byte is an extended make code or F0
// EXT_BRK | E0 F0 seen; next byte is a released extended key, ignored
module ps2_key_ascii_decoder
    import ps2_pkg::*;
#(
    parameter int         DEPTH        = 8,
    parameter bit         LOWERCASE_EN = 1'b1,
    parameter bit         EMIT_UNKNOWN = 1'b1,
    parameter logic [7:0] UNK_CHAR     = 8'h2A
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             scan_code,
    input  logic                   scan_valid,
    output logic [7:0]             ascii_data,
    output logic                   ascii_valid,
    input  logic                   ascii_ready,
    output logic                   shift_active,
    output logic                   caps_active,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_count
);

    ps2_state_e state_q, state_d;
    logic       lshift_q, lshift_d;
    logic       rshift_q, rshift_d;
    logic       caps_q, caps_d;
    logic       overflow_q, overflow_d;

    logic       push_req;
    logic [7:0] push_char;
    logic       fifo_wr_ready;
    logic       fifo_valid;
    logic [7:0] fifo_head;
    logic       upper;
    sc_lookup_t lookup;

    assign shift_active = lshift_q | rshift_q;
    assign caps_active  = caps_q;
    assign overflow     = overflow_q;
    assign ascii_valid  = fifo_valid;
    // Empty buffer shows the unknown marker rather than stale storage
    assign ascii_data   = fifo_valid ? fifo_head : UNK_CHAR;

    assign upper  = !LOWERCASE_EN || (shift_active ^ caps_q);
    assign lookup = sc2ascii(scan_code, upper);

    // Prefix tracking, modifier updates and character push decision
    always_comb begin
        state_d   = state_q;
        lshift_d  = lshift_q;
        rshift_d  = rshift_q;
        caps_d    = caps_q;
        push_req  = 1'b0;
        push_char = UNK_CHAR;
        if (scan_valid) begin
            case (state_q)
                IDLE: begin
                    if (scan_code == SC_BREAK) begin
                        state_d = BREAK;
                    end else if (scan_code == SC_EXT) begin
                        state_d = EXT;
                    end else if (scan_code == SC_LSHIFT) begin
                        lshift_d = 1'b1;
                    end else if (scan_code == SC_RSHIFT) begin
                        rshift_d = 1'b1;
                    end else if (scan_code == SC_CAPS) begin
                        caps_d = ~caps_q;
                    end else if (lookup.hit) begin
                        push_req  = 1'b1;
                        push_char = lookup.chr;
                    end else if (EMIT_UNKNOWN) begin
                        push_req  = 1'b1;
                        push_char = UNK_CHAR;
                    end
                end
                BREAK: begin
                    if (scan_code == SC_LSHIFT) begin
                        lshift_d = 1'b0;
                    end
                    if (scan_code == SC_RSHIFT) begin
                        rshift_d = 1'b0;
                    end
                    state_d = IDLE;
                end
                EXT: begin
                    if (scan_code == SC_BREAK) begin
                        state_d = EXT_BRK;
                    end else begin
                        if (scan_code == SC_KP_ENTER) begin
                            push_req  = 1'b1;
                            push_char = ASCII_CR;
                        end
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        overflow_d = overflow_q | (push_req & ~fifo_wr_ready);
    end

    // Register FSM state, modifiers and the sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lshift_q   <= 1'b0;
            rshift_q   <= 1'b0;
            caps_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lshift_q   <= lshift_d;
            rshift_q   <= rshift_d;
            caps_q     <= caps_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (push_req),
        .wr_data  (push_char),
        .wr_ready (fifo_wr_ready),
        .rd_en    (ascii_ready),
        .rd_data  (fifo_head),
        .rd_valid (fifo_valid),
        .count    (fifo_count)
    );

endmodule

// File: doc/ps2_key_ascii_decoder.md
Name: ps2_key_ascii_decoder

Overview:
Converts the PS/2 Set-2 scan-code byte stream into buffered ASCII characters. Internally it tracks prefix state (make/break/extended), Shift and Caps Lock. Decoded characters go into a FIFO, and the consumer drains it through a valid/ready handshake. The block sits between the PS/2 receiver (one byte per strobe) and the iPod text/command front end.

Parameters:
DEPTH, 8, FIFO entries; power of 2, minimum 2
LOWERCASE_EN, 1, 1 = letters follow Shift XOR Caps; 0 = letters always uppercase (legacy behaviour)
EMIT_UNKNOWN, 1, 1 = an unmapped make code pushes UNK_CHAR; 0 = dropped silently
UNK_CHAR, 8'h2A, character pushed for unmapped codes; also the reset value of ascii_data

Ports:
clk  in  1  clock
rst  in  1  reset
scan_code  in  8  scan-code byte from the PS/2 receiver
scan_valid  in  1  one-cycle strobe; scan_code is valid only in this cycle
ascii_data  out  8  FIFO head character
ascii_valid  out  1  FIFO not empty
ascii_ready  in  1  consumer accepts the head character
shift_active  out  1  left or right Shift currently held
caps_active  out  1  Caps Lock toggle state
overflow  out  1  sticky flag: a character was dropped because the FIFO was full
fifo_count  out  $clog2(DEPTH)+1  number of occupied FIFO entries

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset:
  - state = IDLE, shift = 0, caps = 0
  - FIFO empty, fifo_count = 0, ascii_valid = 0
  - overflow = 0, ascii_data = UNK_CHAR
- Reset mid-stream discards any pending prefix and all buffered characters.
- Prefix FSM; it advances only on cycles where scan_valid = 1.
  - IDLE:
    - 8'hF0 -> BREAK
    - 8'hE0 -> EXT
    - any other code is a make code: process it, stay in IDLE
  - BREAK:
    - any byte is a break code: process it -> IDLE
    - E0 or F0 received here is treated as an ordinary code (no nesting)
  - EXT:
    - F0 -> EXT_BRK
    - E0 5A (keypad Enter) pushes 8'h0D
    - all other extended make codes push nothing
    - -> IDLE
  - EXT_BRK: any byte -> IDLE; no push.
- Modifier handling:
  - Make of 8'h12 or 8'h59 sets that Shift side's held bit; the matching break clears it.
  - shift_active = OR of the two held bits.
  - Make of 8'h58 toggles caps; its break has no effect.
  - Typematic repeat of 8'h58 toggles again each time.
  - Modifiers never push a character.
- Character map: the full Set-2 table covers 0-9, A-Z, the 11 punctuation keys, Space (8'h20), Enter (8'h0D) and Backspace (8'h08).
  - Letters: lowercase (0x61-0x7A) when LOWERCASE_EN=1 and shift XOR caps = 0; otherwise uppercase.
  - Digits and punctuation ignore Shift in this revision.
  - Typematic repeats of make codes push once per received byte.
- Latency: if the FIFO is empty and scan_valid is high at cycle N, ascii_valid = 1 and ascii_data is correct at cycle N+1.
  - The FIFO is first-word-fall-through: ascii_data is stable while ascii_valid = 1 and ascii_ready = 0.
- Handshake:
  - Pop when ascii_valid & ascii_ready.
  - ascii_ready while the FIFO is empty is ignored.
- Boundary conditions:
  - Push while full with no pop in the same cycle: character dropped, overflow set.
  - Push and pop in the same cycle while full: push accepted, count unchanged.
  - Push and pop in the same cycle while empty: not possible, since ascii_valid = 0.
  - Pointers wrap modulo DEPTH.
  - overflow clears only on rst.

Decomposition:
- Package ps2_pkg holds:
  - scan-code constants: SC_BREAK=F0, SC_EXT=E0, SC_LSHIFT=12, SC_RSHIFT=59, SC_CAPS=58, SC_KP_ENTER=5A
  - state enum {IDLE, BREAK, EXT, EXT_BRK}
  - a pure function sc2ascii(code, upper) returning {hit, char}
- Sub-module sync_fifo (WIDTH, DEPTH): FWFT buffer with a count output.
- The top level holds the FSM, the modifier registers and the overflow flag.

Test Plan:
1. Reset, then scan 1C with ascii_ready=1 -> ascii_data=8'h61 one cycle later; with LOWERCASE_EN=0 -> 8'h41.
2. Make 12, then 1C, then F0 12, then 1C -> pushes 41 then 61; shift_active is 1 between the Shift make and break, otherwise 0.
3. Make 58, then F0 58, then 32 -> caps_active=1, push 42. Then 12 then 32 -> push 62 (Shift XOR Caps).
4. F0 16 -> no push. E0 5A -> push 0D. E0 75 -> no push. E0 F0 5A -> no push; FSM back in IDLE, so a following 16 pushes 31.
5. Hold ascii_ready=0, send 9 letters (DEPTH=8) -> fifo_count=8, ninth dropped, overflow=1. Drain -> 8 characters in order. overflow stays 1 until rst.
6. FIFO full, simultaneous scan_valid and ascii_ready -> count stays 8, new char at tail. Assert rst mid-stream (after F0) -> FIFO empty; next 1C pushes 61 (not treated as a break).
